// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes and FSM state encodings.
package alu_sequencer_pkg;

    // Instruction opcodes carried in the top two bits of instr
    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_UNA = 2'b11;

    // Sequencer state encodings
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_LOAD_A = 2'b01;
    localparam logic [1:0] S_EXEC   = 2'b10;
    localparam logic [1:0] S_WRITE  = 2'b11;

    // MV and MVI skip the ALU and go straight to write-back
    function automatic logic is_single_cycle(input logic [1:0] op);
        return (op == OP_MV) || (op == OP_MVI);
    endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// Register file for the ALU sequencer: NREGS x WIDTH entries, one synchronous
// write port, three combinational read ports, cleared asynchronously on resetn.
module alu_sequencer_reg_file #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int REGW  = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             we,
    input  logic [REGW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [REGW-1:0]  raddr_x,
    input  logic [REGW-1:0]  raddr_y,
    input  logic [REGW-1:0]  raddr_dbg,
    output logic [WIDTH-1:0] rdata_x,
    output logic [WIDTH-1:0] rdata_y,
    output logic [WIDTH-1:0] rdata_dbg
);

    logic [WIDTH-1:0] regs [NREGS];

    // Clear every entry on reset, otherwise write one entry when enabled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_x   = regs[raddr_x];
    assign rdata_y   = regs[raddr_y];
    assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller that sequences the shared ALU and owns the register file.
// One instruction per handshake; MV/MVI take one clock to write back, ADD/UNA
// take three (load A, capture ALU result into G, write back).
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int REGW  = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2+2*REGW-1:0]   instr,
    input  logic [WIDTH-1:0]      imm,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic                  alu_op,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  busy,
    output logic                  done,
    input  logic [REGW-1:0]       rd_sel,
    output logic [WIDTH-1:0]      rd_data
);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [REGW-1:0]  rx_q;
    logic [REGW-1:0]  ry_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q;

    logic [1:0]       instr_op;
    logic [REGW-1:0]  instr_rx;
    logic [REGW-1:0]  instr_ry;

    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] ry_data;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    assign instr_op = instr[2+2*REGW-1 -: 2];
    assign instr_rx = instr[2*REGW-1 -: REGW];
    assign instr_ry = instr[REGW-1:0];

    // Sequencer FSM plus the instruction, A and G latches
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            op_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
            imm_q <= '0;
            a_q   <= '0;
            g_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rx_q  <= instr_rx;
                        ry_q  <= instr_ry;
                        imm_q <= imm;
                        state <= is_single_cycle(instr_op) ? S_WRITE : S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    a_q   <= rx_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    g_q   <= alu_result;
                    state <= S_WRITE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pick the write-back source for the instruction in flight
    always_comb begin
        wr_data = g_q;
        case (op_q)
            OP_MV:   wr_data = ry_data;
            OP_MVI:  wr_data = imm_q;
            default: wr_data = g_q;
        endcase
    end

    assign wr_en       = (state == S_WRITE);
    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_WRITE);
    assign alu_a       = a_q;
    assign alu_b       = ry_data;
    assign alu_op      = (op_q == OP_ADD);

    alu_sequencer_reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .REGW  (REGW)
    ) u_reg_file (
        .clock     (clock),
        .resetn    (resetn),
        .we        (wr_en),
        .waddr     (rx_q),
        .wdata     (wr_data),
        .raddr_x   (rx_q),
        .raddr_y   (ry_q),
        .raddr_dbg (rd_sel),
        .rdata_x   (rx_data),
        .rdata_y   (ry_data),
        .rdata_dbg (rd_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the result bus:
// add when alu_op=1, bitwise NOT of b when alu_op=0.
module tb_alu_sequencer;

    localparam int WIDTH = 16;
    localparam int REGW  = 3;

    localparam logic [1:0] T_MV  = 2'b00;
    localparam logic [1:0] T_MVI = 2'b01;
    localparam logic [1:0] T_ADD = 2'b10;
    localparam logic [1:0] T_UNA = 2'b11;

    logic                clock;
    logic                resetn;
    logic                instr_valid;
    logic                instr_ready;
    logic [2+2*REGW-1:0] instr;
    logic [WIDTH-1:0]    imm;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic                alu_op;
    logic [WIDTH-1:0]    alu_result;
    logic                busy;
    logic                done;
    logic [REGW-1:0]     rd_sel;
    logic [WIDTH-1:0]    rd_data;

    int checks;
    int errors;

    alu_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data)
    );

    assign alu_result = alu_op ? (alu_a + alu_b) : ~alu_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one instruction for a single accept edge, return #1 after it
    task automatic issue(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [15:0] immv);
        @(negedge clock);
        instr       = {op, rx, ry};
        imm         = immv;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
    endtask

    // Issue an instruction and wait until the sequencer is back in IDLE
    task automatic run_instr(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input logic [15:0] immv);
        int n;
        issue(op, rx, ry, immv);
        n = (op == T_MV || op == T_MVI) ? 1 : 3;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;
        rd_sel      = '0;
        resetn      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b alu_op=%b expected 0/0/0", busy, done, alu_op);
        end
        for (int r = 0; r < 8; r++) begin
            rd_sel = r[2:0];
            #1;
            checks++;
            if (rd_data !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 0000", r, rd_data);
            end
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_mvi();
        for (int k = 1; k <= 2; k++) begin
            issue(T_MVI, k[2:0], 3'd0, 16'h0001);
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || instr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mvi_done_r%0d: done=%b busy=%b ready=%b expected 1/1/0", k, done, busy, instr_ready);
            end
            @(posedge clock);
            #1;
            checks++;
            if (done !== 1'b0 || instr_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mvi_idle_r%0d: done=%b ready=%b expected 0/1", k, done, instr_ready);
            end
        end
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mvi_r1: got %h expected 0001", rd_data);
        end
        rd_sel = 3'd2;
        #1;
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mvi_r2: got %h expected 0001", rd_data);
        end
    endtask

    task automatic test_add();
        issue(T_ADD, 3'd1, 3'd2, 16'h0000);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_load: busy=%b done=%b expected 1/0", busy, done);
        end
        @(posedge clock);
        #1;
        checks++;
        if (alu_op !== 1'b1 || alu_a !== 16'h0001 || alu_b !== 16'h0001 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_exec: op=%b a=%h b=%h done=%b expected 1/0001/0001/0", alu_op, alu_a, alu_b, done);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_write: done=%b busy=%b expected 1/1", done, busy);
        end
        @(posedge clock);
        #1;
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_data !== 16'h0002 || instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_result: r1=%h ready=%b expected 0002/1", rd_data, instr_ready);
        end
    endtask

    task automatic test_wrap();
        run_instr(T_MVI, 3'd4, 3'd0, 16'hFFFF);
        run_instr(T_MVI, 3'd5, 3'd0, 16'h0002);
        run_instr(T_ADD, 3'd4, 3'd5, 16'h0000);
        rd_sel = 3'd4;
        #1;
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL wrap_r4: got %h expected 0001", rd_data);
        end
        run_instr(T_MVI, 3'd6, 3'd0, 16'h8001);
        run_instr(T_ADD, 3'd6, 3'd6, 16'h0000);
        rd_sel = 3'd6;
        #1;
        checks++;
        if (rd_data !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL double_r6: got %h expected 0002", rd_data);
        end
    endtask

    task automatic test_una();
        run_instr(T_MVI, 3'd5, 3'd0, 16'hFFFE);
        issue(T_UNA, 3'd7, 3'd5, 16'h0000);
        @(posedge clock);
        #1;
        checks++;
        if (alu_op !== 1'b0 || alu_b !== 16'hFFFE) begin
            errors++;
            $display("[TB] FAIL una_exec: op=%b b=%h expected 0/fffe", alu_op, alu_b);
        end
        repeat (2) @(posedge clock);
        #1;
        rd_sel = 3'd7;
        #1;
        checks++;
        if (rd_data !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL una_r7: got %h expected 0001", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        // R1=2, R2=1 here; a single ADD leaves R1=3, a repeated one would give 4
        @(negedge clock);
        instr       = {T_ADD, 3'd1, 3'd2};
        imm         = '0;
        instr_valid = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: ready=%b busy=%b expected 1/0", instr_ready, busy);
        end
        @(negedge clock);
        instr = {T_MV, 3'd0, 3'd1};
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_mv_accept: done=%b expected 1", done);
        end
        @(posedge clock);
        #1;
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_data !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL b2b_r1: got %h expected 0003", rd_data);
        end
        rd_sel = 3'd0;
        #1;
        checks++;
        if (rd_data !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL b2b_r0: got %h expected 0003", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic done_seen;
        done_seen = 1'b0;
        issue(T_ADD, 3'd1, 3'd2, 16'h0000);
        @(posedge clock);
        #1;
        checks++;
        if (alu_op !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_exec: op=%b busy=%b expected 1/1", alu_op, busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: ready=%b busy=%b done=%b expected 1/0/0", instr_ready, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done) done_seen = 1'b1;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: done pulsed=%b expected 0", done_seen);
        end
        rd_sel = 3'd1;
        #1;
        checks++;
        if (rd_data !== 16'h0000 || instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_r1: r1=%h ready=%b expected 0000/1", rd_data, instr_ready);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mvi();
        test_add();
        test_wrap();
        test_una();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
